// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the memory-access stage.
// Holds the access-size encodings, the FSM state enum, the error data
// constant, and small pure functions for alignment and store lane encoding.
package mem_pkg;

  // Access size encoding shared by MemRead_in / MemWrite_in
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  // Value loaded into mem_data_out when an access is dropped or aborted
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } mem_state_e;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=00
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic r;
    case (sz)
      SZ_H:    r = a[0];
      SZ_W:    r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte-lane enables: base mask for the size, moved up to the addressed lane
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] base;
    case (sz)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << a;
  endfunction

  // Store data is replicated so that every lane carries the value; the byte
  // enables then pick the lane that is actually written.
  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects the addressed byte/half of a read word and extends it.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: rdata (raw bus word), addr (low address bits), size (SZ_*),
//        uns (1 = zero-extend), data (aligned, extended result).
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte lane from addr[1:0]; half lane from addr[1] only (addr[0] is 0 for
  // any half access that reaches the bus).
  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = '0;
    case (size)
      SZ_B:    data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_H:    data = {{16{~uns & half_sel[15]}}, half_sel};
      SZ_W:    data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage driving a req/gnt/rvalid data-memory bus.
// Latency: store with immediate grant stalls 1 cycle; load with grant at
//          cycle 0 and rvalid at cycle 1 stalls 2, data valid in DONE.
// Backpressure: stall_req holds EX/MEM and earlier stages until the access
//          completes, times out, or is dropped as misaligned.
// Ports: EX/MEM side (PC_in, inst_in, rd_in, alures_in, rs2_data_in,
//        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in); memory bus
//        (dmem_*); MEM/WB side (*_out, mem_data_out); control/status
//        (stall_req, misalign, timeout_err).
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic [31:0] inst_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] rs2_data_in,
  input  logic [1:0]  MemRead_in,
  input  logic [1:0]  MemWrite_in,
  input  logic [1:0]  RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] PC_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alures_out,
  output logic [1:0]  RegWrite_out,
  output logic [1:0]  MemtoReg_out,
  output logic [31:0] mem_data_out,
  output logic        stall_req,
  output logic        misalign,
  output logic        timeout_err
);

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        terr_q, terr_d;

  logic        is_load, is_store, is_access, misaligned, timeout_hit;
  logic [1:0]  size;
  logic [31:0] load_data;
  logic        unused_inst;

  // Only the unsigned-load bit of the instruction matters here
  assign unused_inst = ^{inst_in[31:15], inst_in[13:0]};

  assign is_load    = (MemRead_in != SZ_NONE);
  assign is_store   = (MemWrite_in != SZ_NONE);
  assign is_access  = is_load | is_store;
  assign size       = is_load ? MemRead_in : MemWrite_in;
  assign misaligned = is_misaligned(size, alures_in[1:0]);

  // The counter holds the number of cycles already spent in the current
  // REQ/WAIT stint, so this cycle is the TIMEOUT-th one when cnt+1 hits it.
  assign timeout_hit = (({1'b0, cnt_q} + 9'd1) == TO_LIM);

  load_align u_load_align (
    .rdata (dmem_rdata),
    .addr  (alures_in[1:0]),
    .size  (MemRead_in),
    .uns   (inst_in[14]),
    .data  (load_data)
  );

  // Request fields come straight from EX/MEM, which is frozen by stall_req,
  // so they stay stable for the whole REQ phase without extra registers.
  assign dmem_we    = is_store;
  assign dmem_addr  = {alures_in[31:2], 2'b00};
  assign dmem_be    = lane_be(size, alures_in[1:0]);
  assign dmem_wdata = store_wdata(MemWrite_in, rs2_data_in);

  assign PC_out       = PC_in;
  assign rd_out       = rd_in;
  assign alures_out   = alures_in;
  assign MemtoReg_out = MemtoReg_in;
  assign mem_data_out = mem_data_q;
  assign timeout_err  = terr_q;

  // Kill write-back for a dropped access (this cycle) or an aborted one
  // (its DONE cycle, flagged by terr_q).
  assign RegWrite_out = (misalign || (state_q == DONE && terr_q)) ? 2'b00 : RegWrite_in;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    mem_data_d = mem_data_q;
    terr_d     = 1'b0;
    dmem_req   = 1'b0;
    stall_req  = 1'b0;
    misalign   = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_access) begin
          if (misaligned) begin
            misalign   = 1'b1;
            mem_data_d = ERR_DATA;
          end else begin
            dmem_req  = 1'b1;
            stall_req = 1'b1;
            if (dmem_gnt) state_d = is_store ? DONE : WAIT;
            else          state_d = REQ;
          end
        end
      end

      REQ: begin
        dmem_req  = 1'b1;
        stall_req = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        // Grant is checked first so a grant on the last allowed cycle wins
        if (dmem_gnt) begin
          state_d = is_store ? DONE : WAIT;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d    = DONE;
          terr_d     = 1'b1;
          mem_data_d = ERR_DATA;
          cnt_d      = '0;
        end
      end

      WAIT: begin
        stall_req = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (dmem_rvalid) begin
          mem_data_d = load_data;
          state_d    = DONE;
          cnt_d      = '0;
        end else if (timeout_hit) begin
          state_d    = DONE;
          terr_d     = 1'b1;
          mem_data_d = ERR_DATA;
          cnt_d      = '0;
        end
      end

      // One unstalled cycle lets the pipeline move the finished instruction on
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_data_q <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
      terr_q     <= terr_d;
    end
  end

endmodule
